t2mi_ts_packet_parser: RTL

T2MI_TS_PACKET_PARSER -- requirements
Module: t2mi_ts_packet_parser

---
 rtl/t2mi_ts_packet_parser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/t2mi_ts_packet_parser.sv
// T2-MI timestamp packet parser: hunts for 0x47, decodes the 3-byte header,
// captures type-0x20 timestamp bodies and skips every other packet type.
module t2mi_ts_packet_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        t2mi_clk,
    input  logic        rst,
    input  logic        t2mi_valid,
    input  logic [7:0]  t2mi_data,
    input  logic        t2mi_sync,
    output logic        ts_valid,
    output logic [39:0] ts_seconds,
    output logic [31:0] ts_subseconds,
    output logic [12:0] ts_utc_offset,
    output logic [3:0]  ts_bandwidth,
    output logic        pkt_error,
    output logic [1:0]  err_code,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  SYNC_BYTE = 8'h47;
    localparam logic [7:0]  TS_TYPE   = 8'h20;
    localparam logic [15:0] TS_LEN    = 16'h000C;
    localparam logic [1:0]  ERR_LEN   = 2'b01;
    localparam logic [1:0]  ERR_RFU   = 2'b10;
    localparam logic [1:0]  ERR_TOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, HDR, TS_BODY, SKIP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   skip_q, skip_d;
    logic [15:0]   hdr_q, hdr_d;
    logic [87:0]   shadow_q, shadow_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [23:0]   hdr_next;
    logic [95:0]   shadow_next;
    logic          accept_c, reject_c;
    logic [1:0]    code_c;

    // Next-state and event decode; sync abort takes priority over byte handling.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        skip_d      = skip_q;
        hdr_d       = hdr_q;
        shadow_d    = shadow_q;
        tout_d      = tout_q;
        accept_c    = 1'b0;
        reject_c    = 1'b0;
        code_c      = 2'b00;
        hdr_next    = {hdr_q, t2mi_data};
        shadow_next = {shadow_q, t2mi_data};

        if (state_q != IDLE && t2mi_sync) begin
            state_d = IDLE;
            if (state_q == HDR || state_q == TS_BODY) begin
                reject_c = 1'b1;
                code_c   = ERR_TOUT;
            end
            if (t2mi_valid && t2mi_data == SYNC_BYTE) begin
                state_d = HDR;
                idx_d   = 4'd0;
            end
        end else if (state_q != IDLE && !t2mi_valid) begin
            if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                if (state_q == HDR || state_q == TS_BODY) begin
                    reject_c = 1'b1;
                    code_c   = ERR_TOUT;
                end
            end else begin
                tout_d = tout_q + TW'(1);
            end
        end else if (t2mi_valid) begin
            tout_d = '0;
            case (state_q)
                IDLE: begin
                    if (t2mi_data == SYNC_BYTE) begin
                        state_d = HDR;
                        idx_d   = 4'd0;
                    end
                end
                HDR: begin
                    hdr_d = hdr_next[15:0];
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd2) begin
                        if (hdr_next[23:16] == TS_TYPE) begin
                            if (hdr_next[15:0] == TS_LEN) begin
                                state_d = TS_BODY;
                                idx_d   = 4'd0;
                            end else begin
                                state_d  = IDLE;
                                reject_c = 1'b1;
                                code_c   = ERR_LEN;
                            end
                        end else if (hdr_next[15:0] == 16'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = SKIP;
                            skip_d  = hdr_next[15:0];
                        end
                    end
                end
                TS_BODY: begin
                    shadow_d = shadow_next[87:0];
                    idx_d    = idx_q + 4'd1;
                    if (idx_q == 4'd11) begin
                        state_d = IDLE;
                        if (shadow_next[95:92] != 4'd0 || shadow_next[87:85] != 3'd0) begin
                            reject_c = 1'b1;
                            code_c   = ERR_RFU;
                        end else begin
                            accept_c = 1'b1;
                        end
                    end
                end
                SKIP: begin
                    skip_d = skip_q - 16'd1;
                    if (skip_q == 16'd1) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end

        if (state_d == IDLE) begin
            tout_d = '0;
        end
    end

    // State and parse context registers.
    always_ff @(posedge t2mi_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            skip_q   <= 16'd0;
            hdr_q    <= 16'd0;
            shadow_q <= 88'd0;
            tout_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            skip_q   <= skip_d;
            hdr_q    <= hdr_d;
            shadow_q <= shadow_d;
            tout_q   <= tout_d;
        end
    end

    // Registered result outputs and saturating statistics.
    always_ff @(posedge t2mi_clk) begin
        if (rst) begin
            ts_valid      <= 1'b0;
            pkt_error     <= 1'b0;
            ts_seconds    <= 40'd0;
            ts_subseconds <= 32'd0;
            ts_utc_offset <= 13'd0;
            ts_bandwidth  <= 4'd0;
            err_code      <= 2'b00;
            pkt_count     <= 16'd0;
            err_count     <= 16'd0;
        end else begin
            ts_valid  <= accept_c;
            pkt_error <= reject_c;
            if (accept_c) begin
                ts_bandwidth  <= shadow_next[91:88];
                ts_utc_offset <= shadow_next[84:72];
                ts_seconds    <= shadow_next[71:32];
                ts_subseconds <= shadow_next[31:0];
                if (pkt_count != 16'hFFFF) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end
            if (reject_c) begin
                err_code <= code_c;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end
endmodule
